// File: rtl/ham_7_4_dec_sched.sv
// ham_7_4_dec_sched
// Round-robin scheduler sharing one serial Hamming(7,4) decoder among up to
// four serial requester channels. Each channel owns a one-codeword capture
// buffer. A granted codeword is shifted into the decoder and the corrected
// serial stream is collected and returned as a parallel word tagged with its
// channel index.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   ch_datain   per-channel serial data
//   ch_dvin     per-channel active-low bit strobe
//   ch_ovf      per-channel one-cycle pulse: bit dropped, buffer full
//   dec_datain  serial data to decoder
//   dec_dvin    active-low strobe to decoder
//   dec_code    serial corrected data from decoder
//   dec_dvout   active-low strobe from decoder
//   res_data    corrected codeword, bit 6 is first on the wire
//   res_ch      channel index of res_data
//   res_vld     one-cycle pulse: res_data/res_ch valid
//   dec_tmo     one-cycle pulse: decoder timeout, codeword discarded
//   busy        high whenever the scheduler is not idle
module ham_7_4_dec_sched #(
  parameter int NCH = 4,
  parameter int TMO = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] ch_datain,
  input  logic [NCH-1:0] ch_dvin,
  output logic [NCH-1:0] ch_ovf,
  output logic           dec_datain,
  output logic           dec_dvin,
  input  logic           dec_code,
  input  logic           dec_dvout,
  output logic [6:0]     res_data,
  output logic [1:0]     res_ch,
  output logic           res_vld,
  output logic           dec_tmo,
  output logic           busy
);

  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT, RECV, DONE} state_t;

  state_t     state_q, state_d;

  logic [6:0] cap_q     [NCH];
  logic [2:0] bit_cnt_q [NCH];
  logic [NCH-1:0] pend_q;

  logic [1:0] last_q;
  logic [1:0] gnt_q;
  logic [6:0] tx_q;
  logic [6:0] rx_q;
  logic [2:0] tx_cnt_q;
  logic [2:0] rx_cnt_q;
  logic [3:0] tmo_cnt_q;

  logic       grant_vld;
  logic [1:0] grant_idx;
  logic       grant_en;
  logic       tmo_hit;
  logic       rx_last;
  logic [2:0] cand;

  // tx shifts in zeros, so after a full codeword the line idles at 0.
  assign dec_datain = tx_q[6];

  // Arbitration and next-state logic.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_idx = last_q;
    grant_en  = 1'b0;
    tmo_hit   = 1'b0;
    rx_last   = 1'b0;
    cand      = 3'd0;

    // Search last+1, last+2, ... wrapping at NCH; first pending wins.
    for (int k = 1; k <= NCH; k++) begin
      cand = {1'b0, last_q} + 3'(k);
      if (cand >= 3'(NCH)) cand = cand - 3'(NCH);
      if (!grant_vld && pend_q[cand[1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[1:0];
      end
    end

    case (state_q)
      IDLE: if (grant_vld) begin
        grant_en = 1'b1;
        state_d  = SEND;
      end
      SEND: if (tx_cnt_q == 3'd6) state_d = GAP;
      // One idle strobe cycle lets the decoder re-arm its bit counter.
      GAP:  state_d = WAIT;
      WAIT: begin
        if (!dec_dvout) begin
          state_d = RECV;
        end else if (tmo_cnt_q == 4'(TMO - 1)) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      RECV: begin
        if (dec_dvout) begin
          // Truncated decoder output is treated like a timeout.
          tmo_hit = 1'b1;
          state_d = IDLE;
        end else if (rx_cnt_q == 3'd6) begin
          rx_last = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Per-channel capture buffers.
  // NOTE: these buffers are small register arrays, not RAM, so they take the
  // reset like any other flop; a RAM-mapped array would be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        cap_q[i]     <= '0;
        bit_cnt_q[i] <= '0;
      end
      pend_q <= '0;
      ch_ovf <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ch_ovf[i] <= 1'b0;
        if (!ch_dvin[i]) begin
          if (pend_q[i]) begin
            ch_ovf[i] <= 1'b1;
          end else begin
            cap_q[i] <= {cap_q[i][5:0], ch_datain[i]};
            if (bit_cnt_q[i] == 3'd6) begin
              bit_cnt_q[i] <= 3'd0;
              pend_q[i]    <= 1'b1;
            end else begin
              bit_cnt_q[i] <= bit_cnt_q[i] + 3'd1;
            end
          end
        end
        // pend is still set during the grant cycle, so a bit arriving then
        // is dropped above; clearing here frees the buffer for the next one.
        if (grant_en && grant_idx == 2'(i)) pend_q[i] <= 1'b0;
      end
    end
  end

  // Decoder-side datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q    <= 2'(NCH - 1);
      gnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tmo_cnt_q <= '0;
      dec_dvin  <= 1'b1;
      res_data  <= '0;
      res_ch    <= '0;
      res_vld   <= 1'b0;
      dec_tmo   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_vld <= rx_last;
      dec_tmo <= tmo_hit;
      busy    <= (state_d != IDLE);

      case (state_q)
        IDLE: if (grant_en) begin
          tx_q     <= cap_q[grant_idx];
          tx_cnt_q <= 3'd0;
          dec_dvin <= 1'b0;
          last_q   <= grant_idx;
          gnt_q    <= grant_idx;
        end
        SEND: begin
          tx_q     <= {tx_q[5:0], 1'b0};
          tx_cnt_q <= tx_cnt_q + 3'd1;
          if (tx_cnt_q == 3'd6) dec_dvin <= 1'b1;
        end
        GAP: tmo_cnt_q <= 4'd0;
        WAIT: begin
          if (!dec_dvout) begin
            rx_q     <= {rx_q[5:0], dec_code};
            rx_cnt_q <= 3'd1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 4'd1;
          end
        end
        RECV: if (!dec_dvout) begin
          rx_q     <= {rx_q[5:0], dec_code};
          rx_cnt_q <= rx_cnt_q + 3'd1;
          if (rx_cnt_q == 3'd6) begin
            res_data <= {rx_q[5:0], dec_code};
            res_ch   <= gnt_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ham_7_4_dec_sched.sv
// Testbench for ham_7_4_dec_sched. A behavioural serial Hamming(7,4) decoder
// sits on the decoder port; expected results are pushed to a scoreboard
// when stimulus is driven and popped when res_vld pulses.
module tb_ham_7_4_dec_sched;

  localparam int NCH = 4;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ch_datain = '0;
  logic [3:0] ch_dvin = '1;
  logic [3:0] ch_ovf;
  logic       dec_datain, dec_dvin;
  logic       dec_code = 1'b0;
  logic       dec_dvout = 1'b1;
  logic [6:0] res_data;
  logic [1:0] res_ch;
  logic       res_vld, dec_tmo, busy;

  always #5 clk = ~clk;

  ham_7_4_dec_sched #(.NCH(NCH), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .ch_datain(ch_datain), .ch_dvin(ch_dvin), .ch_ovf(ch_ovf),
    .dec_datain(dec_datain), .dec_dvin(dec_dvin),
    .dec_code(dec_code), .dec_dvout(dec_dvout),
    .res_data(res_data), .res_ch(res_ch), .res_vld(res_vld),
    .dec_tmo(dec_tmo), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [6:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t popped;

  int cyc = 0;
  int run_len = 0;
  int dvin_rise_cyc = 0;
  int tmo_cyc = 0;
  int tmo_seen = 0;
  int ovf_cnt[4] = '{0, 0, 0, 0};

  // Decoder model state.
  logic [6:0] m_rx = '0;
  logic [6:0] m_out = '0;
  int m_rcnt = 0, m_lat = 0, m_ocnt = 0;
  int hold_cnt = 0;

  // Hamming(7,4): first bit sent (bit 6) is position 1, parity at 1,2,4.
  function automatic logic [6:0] ham_fix(input logic [6:0] w);
    logic [2:0] s;
    logic [6:0] r;
    s = 3'd0;
    r = w;
    for (int p = 1; p <= 7; p++) if (w[7-p]) s = s ^ 3'(p);
    if (s != 3'd0) r[7-int'(s)] = ~r[7-int'(s)];
    return r;
  endfunction

  // Serial decoder model: collects 7 bits while dvin low, then after a
  // short latency streams the corrected word with dvout low.
  always @(negedge clk) begin
    if (!reset) begin
      m_rcnt = 0; m_lat = 0; m_ocnt = 0;
      dec_dvout = 1'b1; dec_code = 1'b0;
    end else begin
      dec_dvout = 1'b1;
      dec_code  = 1'b0;
      if (m_ocnt != 0) begin
        dec_dvout = 1'b0;
        dec_code  = m_out[6];
        m_out     = {m_out[5:0], 1'b0};
        m_ocnt--;
      end else if (m_lat != 0) begin
        m_lat--;
        if (m_lat == 0) m_ocnt = 7;
      end
      if (!dec_dvin) begin
        m_rx = {m_rx[5:0], dec_datain};
        m_rcnt++;
        if (m_rcnt == 7) begin
          m_rcnt = 0;
          if (hold_cnt > 0) hold_cnt--;
          else begin
            m_out = ham_fix(m_rx);
            m_lat = 3;
          end
        end
      end
    end
  end

  // Monitor: scoreboard compare, strobe run length, pulse counters.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      run_len = 0;
    end else begin
      if (!dec_dvin) run_len++;
      else if (run_len != 0) begin
        checks++;
        if (run_len != 7) begin
          errors++;
          $display("FAIL dvin_run: got %0d low cycles, want 7", run_len);
        end
        run_len = 0;
        dvin_rise_cyc = cyc;
      end
      if (res_vld) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected: got ch=%0d data=%b, want no result", res_ch, res_data);
        end else begin
          popped = sb_q.pop_front();
          if ({res_ch, res_data} !== popped) begin
            errors++;
            $display("FAIL res_word: got ch=%0d data=%b, want ch=%0d data=%b",
                     res_ch, res_data, popped.ch, popped.data);
          end
        end
      end
      for (int i = 0; i < 4; i++) ovf_cnt[i] += int'(ch_ovf[i]);
      if (dec_tmo) begin
        tmo_seen++;
        tmo_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive n bits on one channel, bits[n-1] first, one per cycle.
  task automatic drive_bits(input int ch, input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      @(negedge clk); #1;
      ch_dvin[ch]   = 1'b0;
      ch_datain[ch] = bits[k];
    end
    @(negedge clk); #1;
    ch_dvin[ch]   = 1'b1;
    ch_datain[ch] = 1'b0;
  endtask

  // Drive a codeword on every masked channel in parallel; results are
  // expected in channel-index order (caller ensures last grant was ch 3).
  task automatic drive_words(input logic [3:0] mask, input logic [3:0][6:0] words);
    for (int i = 0; i < 4; i++)
      if (mask[i]) sb_q.push_back('{ch: 2'(i), data: ham_fix(words[i])});
    for (int b = 6; b >= 0; b--) begin
      @(negedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (mask[i]) begin
          ch_dvin[i]   = 1'b0;
          ch_datain[i] = words[i][b];
        end
    end
    @(negedge clk); #1;
    ch_dvin   = '1;
    ch_datain = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((sb_q.size() != 0 || busy) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s_drain: got %0d results pending busy=%b after %0d cycles, want 0 pending idle",
               name, sb_q.size(), busy, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (dec_dvin !== 1'b1)  begin errors++; $display("FAIL rst_dvin: got %b want 1", dec_dvin); end
    checks++; if (dec_datain !== 1'b0) begin errors++; $display("FAIL rst_datain: got %b want 0", dec_datain); end
    checks++; if (res_vld !== 1'b0)   begin errors++; $display("FAIL rst_vld: got %b want 0", res_vld); end
    checks++; if (res_data !== 7'd0)  begin errors++; $display("FAIL rst_data: got %b want 0", res_data); end
    checks++; if (res_ch !== 2'd0)    begin errors++; $display("FAIL rst_ch: got %0d want 0", res_ch); end
    checks++; if (ch_ovf !== 4'd0)    begin errors++; $display("FAIL rst_ovf: got %b want 0", ch_ovf); end
    checks++; if (dec_tmo !== 1'b0)   begin errors++; $display("FAIL rst_tmo: got %b want 0", dec_tmo); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b1;
    @(negedge clk); #1;
  endtask

  // Ch 0 sends all-zero; also checks 2-cycle grant latency and first bit.
  task automatic test_basic();
    logic [6:0] w;
    w = 7'b0000000;
    sb_q.push_back('{ch: 2'd0, data: ham_fix(w)});
    drive_bits(0, {25'd0, w}, 7);
    checks++; if (dec_dvin !== 1'b1) begin errors++; $display("FAIL lat_dvin_pend: got %b want 1", dec_dvin); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL lat_busy_pend: got %b want 0", busy); end
    @(negedge clk); #1;
    checks++; if (dec_dvin !== 1'b0) begin errors++; $display("FAIL lat_dvin_grant: got %b want 0", dec_dvin); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL lat_busy_grant: got %b want 1", busy); end
    checks++; if (dec_datain !== w[6]) begin errors++; $display("FAIL first_bit: got %b want %b", dec_datain, w[6]); end
    wait_drain("basic", 100);
  endtask

  task automatic test_single_error();
    sb_q.push_back('{ch: 2'd1, data: 7'b0000000});
    drive_bits(1, {25'd0, 7'b0000100}, 7);
    wait_drain("err1", 100);
    sb_q.push_back('{ch: 2'd2, data: 7'b1111111});
    drive_bits(2, {25'd0, 7'b1111111}, 7);
    wait_drain("ones", 100);
  endtask

  // Bit arriving on the grant edge is dropped; the very next bit starts a
  // fresh codeword that is accepted.
  task automatic test_grant_cycle();
    int base;
    base = ovf_cnt[1];
    sb_q.push_back('{ch: 2'd1, data: ham_fix(7'b0110111)});
    sb_q.push_back('{ch: 2'd1, data: ham_fix(7'b1011010)});
    drive_bits(1, {17'd0, 7'b0110111, 1'b1, 7'b1011010}, 15);
    wait_drain("grant_cycle", 200);
    checks++;
    if (ovf_cnt[1] - base != 1) begin
      errors++;
      $display("FAIL grant_cycle_ovf: got %0d drops want 1", ovf_cnt[1] - base);
    end
  endtask

  // Ch 3 keeps sending while ch 0 occupies the decoder.
  task automatic test_overflow();
    int base3, base0;
    base3 = ovf_cnt[3];
    base0 = ovf_cnt[0];
    sb_q.push_back('{ch: 2'd0, data: ham_fix(7'b1100110)});
    sb_q.push_back('{ch: 2'd3, data: 7'b0110011});
    drive_bits(0, {25'd0, 7'b1100110}, 7);
    drive_bits(3, {22'd0, 7'b0110011, 3'b101}, 10);
    wait_drain("ovf", 200);
    checks++;
    if (ovf_cnt[3] - base3 != 3) begin
      errors++;
      $display("FAIL ovf_ch3: got %0d pulses want 3", ovf_cnt[3] - base3);
    end
    checks++;
    if (ovf_cnt[0] != base0) begin
      errors++;
      $display("FAIL ovf_ch0: got %0d pulses want 0", ovf_cnt[0] - base0);
    end
  endtask

  task automatic test_back_to_back();
    drive_words(4'b1111, {7'b1011010, 7'b1111111, 7'b0000100, 7'b0110011});
    wait_drain("all4", 300);
    drive_words(4'b0001, {7'd0, 7'd0, 7'd0, 7'b0001111});
    wait_drain("after_all4", 100);
  endtask

  // Decoder swallows ch 1's codeword; ch 2 is pending when the timeout fires.
  task automatic test_timeout();
    int base, k;
    base = tmo_seen;
    hold_cnt = 1;
    sb_q.push_back('{ch: 2'd2, data: ham_fix(7'b1110000)});
    drive_bits(1, {25'd0, 7'b0101010}, 7);
    drive_bits(2, {25'd0, 7'b1110000}, 7);
    k = 0;
    while (tmo_seen == base && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (tmo_seen == base) begin
      errors++;
      $display("FAIL tmo_pulse: got no dec_tmo within 100 cycles, want one");
    end else begin
      checks++;
      if (tmo_cyc - dvin_rise_cyc != TMO + 1) begin
        errors++;
        $display("FAIL tmo_delay: got %0d cycles from GAP, want %0d", tmo_cyc - dvin_rise_cyc, TMO + 1);
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b want 0", busy); end
      @(negedge clk); #1;
      checks++; if (dec_tmo !== 1'b0) begin errors++; $display("FAIL tmo_width: got %b want 0", dec_tmo); end
      checks++; if (dec_dvin !== 1'b0) begin errors++; $display("FAIL tmo_next_grant: got dvin %b want 0", dec_dvin); end
    end
    wait_drain("tmo", 100);
    checks++;
    if (tmo_seen - base != 1) begin
      errors++;
      $display("FAIL tmo_count: got %0d pulses want 1", tmo_seen - base);
    end
  endtask

  task automatic test_reset_mid();
    drive_bits(0, {25'd0, 7'b1111111}, 7);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (dec_dvin !== 1'b0) begin errors++; $display("FAIL mid_in_send: got dvin %b want 0", dec_dvin); end
    reset = 1'b0;
    #1;
    checks++; if (dec_dvin !== 1'b1) begin errors++; $display("FAIL mid_rst_dvin: got %b want 1", dec_dvin); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk); #1;
    drive_words(4'b0110, {7'd0, 7'b0010110, 7'b1001100, 7'd0});
    wait_drain("after_rst", 200);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_error();
    test_grant_cycle();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d results outstanding want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
